// File: rtl/scoreboard_pkg.sv
// Shared constants, types and helpers for the score display: active-low
// seven-segment glyphs (seg[0]=a), converter states and BCD adjust.
package scoreboard_pkg;

  localparam int unsigned BCD_DIGITS = 3;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} conv_state_t;

  typedef logic [1:0] digit_idx_t;

  // 0..9 map to digits, 10 to a dash, anything above to an error glyph
  function automatic logic [6:0] seg_glyph(input logic [3:0] v);
    case (v)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      4'd10:   return SEG_DASH;
      default: return SEG_E;
    endcase
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: start in IDLE begins a conversion,
// done_c is high for the single COMMIT cycle while bcd holds the result.
module bin2bcd_seq
  import scoreboard_pkg::*;
#(
  parameter int unsigned BIN_W = 10
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done_c,
  output logic [BCD_W-1:0] bcd,
  output logic [BIN_W-1:0] value
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  conv_state_t              state_q, state_d;
  logic [BIN_W-1:0]         shreg_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [BCD_W-1:0]         bcd_adj_c;
  logic [BCD_W+BIN_W-1:0]   shifted_c;

  assign bcd_adj_c = dabble_adj(bcd);
  assign shifted_c = {bcd_adj_c, shreg_q} << 1;

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = COMMIT;
      COMMIT: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scratch datapath; value keeps the operand of the conversion in flight
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      bcd     <= '0;
      value   <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          shreg_q <= bin;
          value   <= bin;
          bcd     <= '0;
          cnt_q   <= CNT_W'(BIN_W);
        end
        SHIFT: begin
          bcd     <= shifted_c[BCD_W+BIN_W-1:BIN_W];
          shreg_q <= shifted_c[BIN_W-1:0];
          cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/score_display_mux.sv
// Runs/wickets driver for a 4-digit common-anode display, scanned from a
// synchronized 1 kHz tick. Define LEADING_ZERO_BLANK_EN to blank leading runs zeros.
module score_display_mux
  import scoreboard_pkg::*;
#(
  parameter int unsigned RUNS_W      = 10,
  parameter int unsigned RUNS_MAX    = 999,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  DP_MASK     = 4'b0010
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic              clk_1kHz,
  input  logic [RUNS_W-1:0] runs,
  input  logic [3:0]        wickets,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [3:0]        an
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   scan_tick_c;
  digit_idx_t             idx_q;
  logic [RUNS_W-1:0]      runs_sat_c;
  logic [RUNS_W-1:0]      last_conv_q;
  logic [BCD_W-1:0]       disp_q;
  logic [BCD_W-1:0]       conv_bcd;
  logic [RUNS_W-1:0]      conv_value;
  logic                   conv_done_c;
  logic [BCD_W-1:0]       bcd_eff_c;
  logic [3:0]             digit_val_c;
  logic                   blank_c;
  logic [6:0]             digit_seg_c;

  // clk_1kHz is treated purely as data
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], clk_1kHz};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign scan_tick_c = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  assign runs_sat_c = (runs > RUNS_W'(RUNS_MAX)) ? RUNS_W'(RUNS_MAX) : runs;

  bin2bcd_seq #(.BIN_W(RUNS_W)) u_bin2bcd (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .start    (runs_sat_c != last_conv_q),
    .bin      (runs_sat_c),
    .done_c   (conv_done_c),
    .bcd      (conv_bcd),
    .value    (conv_value)
  );

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      disp_q      <= '0;
      last_conv_q <= '0;
    end else if (conv_done_c) begin
      disp_q      <= conv_bcd;
      last_conv_q <= conv_value;
    end
  end

  // A scan coinciding with COMMIT shows the value being committed
  assign bcd_eff_c = conv_done_c ? conv_bcd : disp_q;

  always_comb begin
    digit_val_c = 4'd0;
    blank_c     = 1'b0;
    case (idx_q)
      2'd3: begin
        digit_val_c = bcd_eff_c[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        blank_c = (bcd_eff_c[11:8] == 4'd0);
`endif
      end
      2'd2: begin
        digit_val_c = bcd_eff_c[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        blank_c = (bcd_eff_c[11:4] == 8'd0);
`endif
      end
      2'd1:    digit_val_c = bcd_eff_c[3:0];
      default: digit_val_c = wickets;
    endcase
    digit_seg_c = blank_c ? SEG_BLANK : seg_glyph(digit_val_c);
  end

  // Each tick drives the current digit, then advances the index
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else if (scan_tick_c) begin
      idx_q <= idx_q + 2'd1;
      an    <= ~(4'b0001 << idx_q);
      seg   <= digit_seg_c;
      dp    <= ~DP_MASK[idx_q];
    end
  end

endmodule
